// File: rtl/scan_chain_sequencer_pkg.sv
// Shared types and sizing helpers for the scan chain sequencer.
package scan_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        LATCH,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    localparam int DEF_NUM_DESIGNS = 5;
    localparam int DEF_IO_W        = 8;
    localparam int DEF_CLK_DIV     = 1;

    // $clog2 that never returns a zero width
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // total number of chain positions
    function automatic int chain_len(input int num_designs, input int io_w);
        return num_designs * io_w;
    endfunction

    // bit counter must hold 0..len without wrapping
    function automatic int bit_cnt_w(input int len);
        return clog2_min1(len + 1);
    endfunction

    // phase counter covers one full scan_clk period of 2*div cycles
    function automatic int phase_w(input int div);
        return clog2_min1(2 * div);
    endfunction

endpackage

// File: rtl/scan_chain_sequencer_if.sv
// Request/response handshake between the scan controller and the sequencer.
interface scan_chain_sequencer_if #(
    parameter int SEL_W = 3,
    parameter int IO_W  = 8
);
    logic             start;
    logic [SEL_W-1:0] active_sel;
    logic [IO_W-1:0]  inputs;
    logic             busy;
    logic             done;
    logic [IO_W-1:0]  outputs;
    logic             sel_err;

    modport master (
        output start, active_sel, inputs,
        input  busy, done, outputs, sel_err
    );

    modport slave (
        input  start, active_sel, inputs,
        output busy, done, outputs, sel_err
    );
endinterface

// File: rtl/scan_chain_sequencer_clk_gen.sv
// Scan clock generator: one bit period is CLK_DIV low cycles then CLK_DIV high cycles.
module scan_clk_gen
    import scan_seq_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,        // counter advances while high, parked at 0 otherwise
    input  logic clk_on,     // allows scan_clk to go high during the high half
    input  logic clr,        // restart the period on the next cycle
    output logic scan_clk,
    output logic first_low,
    output logic last_low,
    output logic period_end
);
    localparam int PH_W = phase_w(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST     = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF     = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LOW_LAST = PH_W'(CLK_DIV - 1);

    logic [PH_W-1:0] ph;

    // phase counter: counts 0..2D-1 while running, never wraps mid-period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ph <= '0;
        else if (clr || !run || ph == PH_LAST)
            ph <= '0;
        else
            ph <= ph + PH_W'(1);
    end

    assign scan_clk   = run & clk_on & (ph >= PH_HALF);
    assign first_low  = run & (ph == '0);
    assign last_low   = run & (ph == PH_LOW_LAST);
    assign period_end = run & (ph == PH_LAST);

endmodule

// File: rtl/scan_chain_sequencer.sv
// Chain-protocol engine: shift a byte into one design's slot, latch, capture,
// shift the whole chain back and return that design's output byte.
module scan_chain_sequencer
    import scan_seq_pkg::*;
#(
    parameter int NUM_DESIGNS = DEF_NUM_DESIGNS,
    parameter int IO_W        = DEF_IO_W,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int SEL_W       = clog2_min1(NUM_DESIGNS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    scan_chain_sequencer_if.slave   bus,
    output logic                    scan_clk_out,
    output logic                    scan_data_out,
    output logic                    scan_select,
    output logic                    scan_latch_en,
    input  logic                    scan_data_in
);
    localparam int L    = chain_len(NUM_DESIGNS, IO_W);
    localparam int BC_W = bit_cnt_w(L);
    localparam int BI_W = clog2_min1(IO_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(L - 1);

    state_t           state, state_nx;
    logic [BC_W-1:0]  bit_cnt;
    logic [SEL_W-1:0] sel_q;
    logic [IO_W-1:0]  din_q;
    logic [IO_W-1:0]  res;
    int               q;
    logic             slot_hit;
    logic [BI_W-1:0]  bidx;
    logic             run, clk_on, clr;
    logic             first_low, last_low, period_end;

    scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .clk_on     (clk_on),
        .clr        (clr),
        .scan_clk   (scan_clk_out),
        .first_low  (first_low),
        .last_low   (last_low),
        .period_end (period_end)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state: every phase ends on a scan_clk period boundary
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (bus.start) state_nx = SHIFT_IN;
            SHIFT_IN:  if (period_end && bit_cnt == LAST_BIT) state_nx = LATCH;
            LATCH:     if (period_end) state_nx = CAPTURE;
            CAPTURE:   if (last_low && bit_cnt == BC_W'(1)) state_nx = SHIFT_OUT;
            SHIFT_OUT: if (period_end && bit_cnt == LAST_BIT) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // chain position addressed by the current bit period; the farthest stage goes first
    always_comb begin
        q        = L - 1 - int'(bit_cnt);
        slot_hit = ((q / IO_W) == int'(sel_q));
        bidx     = BI_W'(q % IO_W);
    end

    // outputs decoded from state; in CAPTURE bit_cnt 0 is the select period, 1 the low tail
    always_comb begin
        run           = (state == SHIFT_IN) || (state == LATCH) ||
                        (state == CAPTURE)  || (state == SHIFT_OUT);
        clk_on        = (state == SHIFT_IN) || (state == SHIFT_OUT) ||
                        ((state == CAPTURE) && (bit_cnt == '0));
        clr           = (state == CAPTURE) && (state_nx == SHIFT_OUT);
        scan_latch_en = (state == LATCH);
        scan_select   = (state == CAPTURE) && (bit_cnt == '0);
        scan_data_out = (state == SHIFT_IN) && slot_hit && din_q[bidx];
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
    end

    // period counter: cleared on every state change, so it never wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bit_cnt <= '0;
        else if (state != state_nx)
            bit_cnt <= '0;
        else if (period_end)
            bit_cnt <= bit_cnt + BC_W'(1);
    end

    // request capture and result assembly; cleared at the start of the unload
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            sel_q <= bus.active_sel;
            din_q <= bus.inputs;
        end
        if (state == SHIFT_OUT && bit_cnt == '0 && first_low)
            res <= '0;
        if (state == SHIFT_OUT && last_low && slot_hit)
            res[bidx] <= scan_data_in;
    end

    // result registers publish together with done and hold until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.outputs <= '0;
            bus.sel_err <= 1'b0;
        end else if (state == SHIFT_OUT && state_nx == DONE) begin
            bus.outputs <= res;
            bus.sel_err <= (int'(sel_q) >= NUM_DESIGNS);
        end
    end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Directed bench: two sequencers (CLK_DIV 1 and 3) each driving a behavioural scan chain.
module tb_scan_chain_sequencer;
    localparam int L = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    scan_chain_sequencer_if #(.SEL_W(3), .IO_W(8)) bus1 ();
    scan_chain_sequencer_if #(.SEL_W(3), .IO_W(8)) bus3 ();

    logic sclk1, sdo1, ssel1, slat1, sdi1;
    logic sclk3, sdo3, ssel3, slat3, sdi3;

    scan_chain_sequencer #(.NUM_DESIGNS(5), .IO_W(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave),
        .scan_clk_out(sclk1), .scan_data_out(sdo1), .scan_select(ssel1),
        .scan_latch_en(slat1), .scan_data_in(sdi1)
    );

    scan_chain_sequencer #(.NUM_DESIGNS(5), .IO_W(8), .CLK_DIV(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3.slave),
        .scan_clk_out(sclk3), .scan_data_out(sdo3), .scan_select(ssel3),
        .scan_latch_en(slat3), .scan_data_in(sdi3)
    );

    // chain models: bit p of ch/mdi is chain position p (design p/8, bit p%8)
    logic [L-1:0] ch1 = '0, mdi1 = '0, ch3 = '0, mdi3 = '0;
    bit inv1 = 1'b0, inv3 = 1'b0;
    wire [L-1:0] mdo1 = inv1 ? ~mdi1 : mdi1;
    wire [L-1:0] mdo3 = inv3 ? ~mdi3 : mdi3;
    assign sdi1 = ch1[L-1];
    assign sdi3 = ch3[L-1];

    always @(posedge sclk1) ch1 <= ssel1 ? mdo1 : {ch1[L-2:0], sdo1};
    always @(posedge sclk3) ch3 <= ssel3 ? mdo3 : {ch3[L-2:0], sdo3};
    always @(posedge clk) if (slat1) mdi1 <= ch1;
    always @(posedge clk) if (slat3) mdi3 <= ch3;

    // protocol monitor: latch/select exclusive and stable while scan_clk is high
    int viol1 = 0, viol3 = 0;
    logic p_lat1 = 1'b0, p_sel1 = 1'b0, p_lat3 = 1'b0, p_sel3 = 1'b0;
    always @(negedge clk) begin
        if ((slat1 && ssel1) || (sclk1 && (slat1 != p_lat1 || ssel1 != p_sel1)))
            viol1 <= viol1 + 1;
        if ((slat3 && ssel3) || (sclk3 && (slat3 != p_lat3 || ssel3 != p_sel3)))
            viol3 <= viol3 + 1;
        p_lat1 <= slat1; p_sel1 <= ssel1;
        p_lat3 <= slat3; p_sel3 <= ssel3;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int inst, input logic st, input logic [2:0] sel, input logic [7:0] din);
        if (inst == 0) begin
            bus1.start = st; bus1.active_sel = sel; bus1.inputs = din;
        end else begin
            bus3.start = st; bus3.active_sel = sel; bus3.inputs = din;
        end
    endtask

    function automatic logic done_of(input int inst);
        return (inst == 0) ? bus1.done : bus3.done;
    endfunction

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? bus1.busy : bus3.busy;
    endfunction

    // one transaction; latency counted in cycles from the start cycle to the done cycle
    task automatic run_txn(input int inst, input logic [2:0] sel, input logic [7:0] din,
                           input int bump_at, input bit restart,
                           output int lat, output int ndone,
                           output logic busy_first, output logic busy_post);
        int k;
        logic st;
        lat = -1; ndone = 0; busy_first = 1'b0; busy_post = 1'b1;
        @(negedge clk); drive(inst, 1'b1, sel, din);
        @(negedge clk); drive(inst, 1'b0, sel, din);
        k = 1;
        busy_first = busy_of(inst);
        while (k < 1200 && (lat < 0 || k <= lat + 4)) begin
            st = 1'b0;
            if (done_of(inst)) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    st  = restart;
                end
            end
            if (k == bump_at) st = 1'b1;
            if (lat >= 0 && k == lat + 1) busy_post = busy_of(inst);
            drive(inst, st, st ? 3'd1 : sel, st ? 8'hFF : din);
            @(negedge clk);
            k++;
        end
        drive(inst, 1'b0, sel, din);
    endtask

    initial begin
        int lat, nd, k;
        logic bf, bp;

        drive(0, 1'b0, 3'd0, 8'h00);
        drive(1, 1'b0, 3'd0, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_state", {bus1.busy, bus1.done, bus1.sel_err, sclk1, sdo1, ssel1, slat1, bus1.outputs}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // sel 0, loopback
        inv1 = 1'b0;
        run_txn(0, 3'd0, 8'hA5, -1, 1'b0, lat, nd, bf, bp);
        check("t1_latency", lat, 166);
        check("t1_ndone", nd, 1);
        check("t1_busy_first", bf, 1);
        check("t1_busy_post", bp, 0);
        check("t1_outputs", bus1.outputs, 8'hA5);
        check("t1_sel_err", bus1.sel_err, 0);
        check("t1_slot0", mdi1[7:0], 8'hA5);
        for (int d = 1; d < 5; d++) check($sformatf("t1_slot%0d", d), mdi1[d*8 +: 8], 8'h00);

        // reset asserted in the middle of SHIFT_IN
        @(negedge clk); drive(0, 1'b1, 3'd2, 8'h5A);
        @(negedge clk); drive(0, 1'b0, 3'd2, 8'h5A);
        for (k = 1; k < 20; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", bus1.outputs, 8'h00);
        check("rst_mid_all", {bus1.busy, bus1.done, bus1.sel_err, sclk1, sdo1, ssel1, slat1}, 0);
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
        nd = 0;
        for (k = 0; k < 200; k++) begin
            if (bus1.done) nd++;
            @(negedge clk);
        end
        check("rst_mid_no_done", nd, 0);
        run_txn(0, 3'd1, 8'h96, -1, 1'b0, lat, nd, bf, bp);
        check("rst_after_latency", lat, 166);
        check("rst_after_outputs", bus1.outputs, 8'h96);
        check("rst_after_slot1", mdi1[15:8], 8'h96);

        // sel 4, inverting designs, start pulsed on the done cycle
        inv1 = 1'b1;
        run_txn(0, 3'd4, 8'h3C, -1, 1'b1, lat, nd, bf, bp);
        check("t2_latency", lat, 166);
        check("t2_outputs", bus1.outputs, 8'hC3);
        check("t2_sel_err", bus1.sel_err, 0);
        check("t2_slot4", mdi1[39:32], 8'h3C);
        check("t2_slot0", mdi1[7:0], 8'h00);
        check("t2_start_on_done_ignored", bp, 0);

        // out-of-range select
        run_txn(0, 3'd7, 8'hFF, -1, 1'b0, lat, nd, bf, bp);
        check("t3_latency", lat, 166);
        check("t3_all_slots_zero", mdi1, 0);
        check("t3_outputs", bus1.outputs, 8'h00);
        check("t3_sel_err", bus1.sel_err, 1);

        // start pulsed while busy
        inv1 = 1'b0;
        run_txn(0, 3'd2, 8'h5A, 50, 1'b0, lat, nd, bf, bp);
        check("t4_latency", lat, 166);
        check("t4_ndone", nd, 1);
        check("t4_busy_post", bp, 0);
        check("t4_outputs", bus1.outputs, 8'h5A);
        check("t4_sel_err", bus1.sel_err, 0);
        check("t4_slot1", mdi1[15:8], 8'h00);

        // CLK_DIV = 3
        inv3 = 1'b0;
        run_txn(1, 3'd3, 8'h81, -1, 1'b0, lat, nd, bf, bp);
        check("d3_latency", lat, 496);
        check("d3_ndone", nd, 1);
        check("d3_outputs", bus3.outputs, 8'h81);
        check("d3_slot3", mdi3[31:24], 8'h81);
        check("d3_slot0", mdi3[7:0], 8'h00);

        check("proto_div1", viol1, 0);
        check("proto_div3", viol3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
